mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave for the CPU's MAR/MDR bus.
// A request (CE low with OE or WE low) is latched in IDLE, waits a fixed
// number of cycles, then completes with a single-cycle ready pulse on R.
// Address IO_ADDR maps to the switch inputs (read) and the hex display
// register (write). All other addresses index an internal word array.

module mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        R,
    output logic [15:0] HEX_out
);

    localparam int unsigned Depth    = 1 << ADDR_BITS;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // Reject builds the wait counter cannot represent.
    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 16) begin : g_bad_addr
        $error("mem_responder: ADDR_BITS must be in 1..16");
    end

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [3:0]           r_count;
    logic [ADDR_BITS-1:0] r_index;
    logic [15:0]          r_wdata;
    logic                 r_is_write;
    logic                 r_is_io;
    logic [15:0]          r_data_out;
    logic [15:0]          r_hex;
    logic [15:0]          r_mem [Depth];

    logic                 w_req;
    logic                 w_accept;
    logic                 w_commit;
    logic [15:0]          w_mem_rdata;

    // A request needs CE low plus at least one strobe; WE wins when both are low.
    assign w_req    = ~CE & (~OE | ~WE);
    assign w_accept = (r_state == S_IDLE) && w_req;

    // The commit edge is the one that moves WAIT into RESP. The counter is
    // loaded on the accept edge and must drain to zero first, which places
    // RESP WAIT_STATES+1 edges after acceptance.
    assign w_commit = (r_state == S_WAIT) && (r_count == 4'd0);

    assign w_mem_rdata = r_mem[r_index];

    // Next-state decode for the request handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_state_next = S_WAIT;
            S_WAIT: if (r_count == 4'd0) w_state_next = S_RESP;
            S_RESP: w_state_next = S_HOLD;
            S_HOLD: if (!w_req) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_count <= WaitLoad;
            end else if (r_state == S_WAIT && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Request capture; the bus is ignored until the next accept.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_index    <= '0;
            r_wdata    <= 16'h0000;
            r_is_write <= 1'b0;
            r_is_io    <= 1'b0;
        end else if (w_accept) begin
            r_index    <= ADDR[ADDR_BITS-1:0];
            r_wdata    <= Data_from_CPU;
            r_is_write <= ~WE;
            r_is_io    <= (ADDR == IO_ADDR);
        end
    end

    // Read data and hex register update only on the commit edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data_out <= 16'h0000;
            r_hex      <= 16'h0000;
        end else if (w_commit) begin
            if (r_is_write) begin
                if (r_is_io) r_hex <= r_wdata;
            end else begin
                r_data_out <= r_is_io ? Switches : w_mem_rdata;
            end
        end
    end

    // Word array write port; contents survive reset. Reset forces IDLE, so an
    // uncommitted write can never reach the array.
    always_ff @(posedge Clk) begin
        if (w_commit && r_is_write && !r_is_io) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign R           = (r_state == S_RESP);
    assign Data_to_CPU = r_data_out;
    assign HEX_out     = r_hex;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic checked
// against a flat array model of memory, hex register and last read value.

module tb_mem_responder;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        CE = 1'b1, OE = 1'b1, WE = 1'b1;
    logic [15:0] ADDR = 16'h0000, Data_from_CPU = 16'h0000, Switches = 16'h0000;
    logic [15:0] Data_to_CPU, HEX_out;
    logic        R;

    logic        ce0 = 1'b1, oe0 = 1'b1, we0 = 1'b1;
    logic [15:0] addr0 = 16'h0000, din0 = 16'h0000;
    logic [15:0] dout0, hex0;
    logic        r0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem_model [256];
    logic [15:0] hex_model = 16'h0000;
    logic [15:0] rd_model  = 16'h0000;

    always #5 Clk = ~Clk;

    mem_responder #(.ADDR_BITS(8), .WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .OE(OE), .WE(WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Switches(Switches),
        .Data_to_CPU(Data_to_CPU), .R(R), .HEX_out(HEX_out)
    );

    mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
        .Clk(Clk), .Reset(Reset), .CE(ce0), .OE(oe0), .WE(we0), .ADDR(addr0),
        .Data_from_CPU(din0), .Switches(Switches),
        .Data_to_CPU(dout0), .R(r0), .HEX_out(hex0)
    );

    // Reference behaviour: returns the value a read must deliver.
    task automatic model_apply(input bit is_wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] sw,
                               output logic [15:0] exp_rd);
        if (is_wr) begin
            if (addr == 16'hFFFF) hex_model = wdata;
            else mem_model[addr[7:0]] = wdata;
        end else begin
            rd_model = (addr == 16'hFFFF) ? sw : mem_model[addr[7:0]];
        end
        exp_rd = rd_model;
    endtask

    // One request on the main DUT. lat = edges from acceptance to the R cycle.
    task automatic issue(input bit is_wr, input bit both, input logic [15:0] addr,
                         input logic [15:0] wdata, input int hold, input logic [15:0] sw_new,
                         output int lat, output int pulses, output logic [15:0] rdata,
                         output logic [15:0] hex_r);
        @(negedge Clk);
        ADDR = addr; Data_from_CPU = wdata; CE = 1'b0;
        WE = is_wr ? 1'b0 : 1'b1;
        OE = (is_wr && !both) ? 1'b1 : 1'b0;
        lat = -1; pulses = 0; rdata = 16'hxxxx; hex_r = 16'hxxxx;
        for (int c = 1; c <= hold + WS + 6; c++) begin
            @(posedge Clk); #1;
            if (R === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = c - 1; rdata = Data_to_CPU; hex_r = HEX_out; end
            end
            if (c == 1) Switches = sw_new;
            if (c == hold) begin
                CE = 1'b1; OE = 1'b1; WE = 1'b1;
                ADDR = 16'($urandom); Data_from_CPU = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset;
        #2 Reset = 1'b1;
        #1;
        if (R !== 1'b0) begin n_fail++; $display("FAIL reset_R: got %b expected 0", R); end
        n_tests++;
        if (Data_to_CPU !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0000", Data_to_CPU);
        end
        n_tests++;
        if (HEX_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_hex: got %h expected 0000", HEX_out);
        end
        n_tests++;
        if (r0 !== 1'b0) begin n_fail++; $display("FAIL reset_R_ws0: got %b expected 0", r0); end
        n_tests++;
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat, pulses; logic [15:0] rd, hx, exp;
        issue(1'b1, 1'b0, 16'h0012, 16'hBEEF, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b1, 16'h0012, 16'hBEEF, 16'h0, exp);
        if (lat != WS + 1) begin n_fail++; $display("FAIL basic_wr_lat: got %0d expected %0d", lat, WS + 1); end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL basic_wr_pulses: got %0d expected 1", pulses); end
        n_tests++;
        issue(1'b0, 1'b0, 16'h0012, 16'h0000, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b0, 16'h0012, 16'h0, 16'h0, exp);
        if (lat != WS + 1) begin n_fail++; $display("FAIL basic_rd_lat: got %0d expected %0d", lat, WS + 1); end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL basic_rd_pulses: got %0d expected 1", pulses); end
        n_tests++;
        if (rd !== exp) begin n_fail++; $display("FAIL basic_rd_data: got %h expected %h", rd, exp); end
        n_tests++;
        if (Data_to_CPU !== exp) begin
            n_fail++; $display("FAIL basic_rd_hold: got %h expected %h", Data_to_CPU, exp);
        end
        n_tests++;
    endtask

    task automatic test_io;
        int lat, pulses; logic [15:0] rd, hx, exp;
        issue(1'b1, 1'b0, 16'h00FF, 16'h5A5A, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b1, 16'h00FF, 16'h5A5A, 16'h0, exp);
        issue(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1, 16'h00A5, lat, pulses, rd, hx);
        model_apply(1'b0, 16'hFFFF, 16'h0, 16'h00A5, exp);
        if (rd !== exp) begin n_fail++; $display("FAIL io_rd_switches: got %h expected %h", rd, exp); end
        n_tests++;
        issue(1'b1, 1'b0, 16'hFFFF, 16'h1234, 1, 16'h0F0F, lat, pulses, rd, hx);
        model_apply(1'b1, 16'hFFFF, 16'h1234, 16'h0, exp);
        if (hx !== hex_model) begin n_fail++; $display("FAIL io_hex_at_R: got %h expected %h", hx, hex_model); end
        n_tests++;
        if (Data_to_CPU !== rd_model) begin
            n_fail++; $display("FAIL io_data_hold: got %h expected %h", Data_to_CPU, rd_model);
        end
        n_tests++;
        issue(1'b0, 1'b0, 16'h00FF, 16'h0000, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b0, 16'h00FF, 16'h0, 16'h0, exp);
        if (rd !== exp) begin n_fail++; $display("FAIL io_array_untouched: got %h expected %h", rd, exp); end
        n_tests++;
    endtask

    task automatic test_alias;
        int lat, pulses; logic [15:0] rd, hx, exp;
        issue(1'b1, 1'b0, 16'h0105, 16'h7777, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b1, 16'h0105, 16'h7777, 16'h0, exp);
        issue(1'b0, 1'b0, 16'h0005, 16'h0000, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b0, 16'h0005, 16'h0, 16'h0, exp);
        if (rd !== exp) begin n_fail++; $display("FAIL alias_rd: got %h expected %h", rd, exp); end
        n_tests++;
    endtask

    task automatic test_held_and_priority;
        int lat, pulses; logic [15:0] rd, hx, exp;
        issue(1'b0, 1'b0, 16'h0012, 16'h0000, 10, Switches, lat, pulses, rd, hx);
        model_apply(1'b0, 16'h0012, 16'h0, 16'h0, exp);
        if (pulses != 1) begin n_fail++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
        n_tests++;
        if (rd !== exp) begin n_fail++; $display("FAIL held_rd: got %h expected %h", rd, exp); end
        n_tests++;
        issue(1'b1, 1'b1, 16'h0020, 16'h4242, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b1, 16'h0020, 16'h4242, 16'h0, exp);
        if (Data_to_CPU !== rd_model) begin
            n_fail++; $display("FAIL prio_no_read: got %h expected %h", Data_to_CPU, rd_model);
        end
        n_tests++;
        issue(1'b0, 1'b0, 16'h0020, 16'h0000, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b0, 16'h0020, 16'h0, 16'h0, exp);
        if (rd !== exp) begin n_fail++; $display("FAIL prio_write_rd: got %h expected %h", rd, exp); end
        n_tests++;
    endtask

    task automatic test_reset_mid_write;
        int lat, pulses, seen; logic [15:0] rd, hx, exp;
        issue(1'b1, 1'b0, 16'h0003, 16'h0001, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b1, 16'h0003, 16'h0001, 16'h0, exp);
        seen = 0;
        @(negedge Clk);
        ADDR = 16'h0003; Data_from_CPU = 16'hDEAD; CE = 1'b0; WE = 1'b0; OE = 1'b1;
        @(posedge Clk); #1;
        CE = 1'b1; WE = 1'b1;
        @(posedge Clk); #1;
        if (R === 1'b1) seen++;
        Reset = 1'b1;
        #1;
        if (HEX_out !== 16'h0000) begin n_fail++; $display("FAIL midrst_hex: got %h expected 0000", HEX_out); end
        n_tests++;
        if (Data_to_CPU !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_data: got %h expected 0000", Data_to_CPU);
        end
        n_tests++;
        hex_model = 16'h0000; rd_model = 16'h0000;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) @(negedge Clk) Reset = 1'b0;
            @(posedge Clk); #1;
            if (R === 1'b1) seen++;
        end
        if (seen != 0) begin n_fail++; $display("FAIL midrst_no_R: got %0d pulses expected 0", seen); end
        n_tests++;
        issue(1'b0, 1'b0, 16'h0003, 16'h0000, 1, Switches, lat, pulses, rd, hx);
        model_apply(1'b0, 16'h0003, 16'h0, 16'h0, exp);
        if (rd !== exp) begin n_fail++; $display("FAIL midrst_not_committed: got %h expected %h", rd, exp); end
        n_tests++;
    endtask

    task automatic test_random;
        int lat, pulses; logic [15:0] rd, hx, exp, addr, wd, sw; logic [7:0] up, lo;
        bit is_wr, both;
        for (int i = 0; i < 16; i++) begin
            up = 8'($urandom); wd = 16'($urandom);
            addr = {up, 8'h30 + 8'(i)};
            issue(1'b1, 1'b0, addr, wd, 1, Switches, lat, pulses, rd, hx);
            model_apply(1'b1, addr, wd, 16'h0, exp);
        end
        for (int i = 0; i < 30; i++) begin
            up = 8'($urandom); lo = 8'($urandom_range(0, 15));
            addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : {up, 8'h30 + lo};
            is_wr = 1'($urandom); both = 1'($urandom);
            wd = 16'($urandom); sw = 16'($urandom);
            issue(is_wr, both, addr, wd, int'($urandom_range(1, 4)), sw, lat, pulses, rd, hx);
            model_apply(is_wr, addr, wd, sw, exp);
            if (lat != WS + 1 || pulses != 1) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: got lat %0d pulses %0d expected lat %0d pulses 1",
                         i, lat, pulses, WS + 1);
            end
            n_tests++;
            if (rd !== exp) begin
                n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, rd, exp);
            end
            n_tests++;
            if (HEX_out !== hex_model) begin
                n_fail++; $display("FAIL rand_hex[%0d]: got %h expected %h", i, HEX_out, hex_model);
            end
            n_tests++;
        end
    endtask

    task automatic test_ws0;
        int lat, pulses; logic [15:0] rd;
        for (int op = 0; op < 2; op++) begin
            @(negedge Clk);
            addr0 = 16'h0044; din0 = 16'hC0DE; ce0 = 1'b0;
            we0 = (op == 0) ? 1'b0 : 1'b1; oe0 = (op == 0) ? 1'b1 : 1'b0;
            lat = -1; pulses = 0; rd = 16'hxxxx;
            for (int c = 1; c <= 6; c++) begin
                @(posedge Clk); #1;
                if (r0 === 1'b1) begin
                    pulses++;
                    if (lat < 0) begin lat = c - 1; rd = dout0; end
                end
                if (c == 1) begin ce0 = 1'b1; oe0 = 1'b1; we0 = 1'b1; din0 = 16'h0000; end
            end
            if (lat != 1 || pulses != 1) begin
                n_fail++;
                $display("FAIL ws0_timing[%0d]: got lat %0d pulses %0d expected lat 1 pulses 1",
                         op, lat, pulses);
            end
            n_tests++;
        end
        if (rd !== 16'hC0DE) begin n_fail++; $display("FAIL ws0_data: got %h expected c0de", rd); end
        n_tests++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_io();
        test_alias();
        test_held_and_priority();
        test_reset_mid_write();
        test_random();
        test_ws0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
